led_dimmer: RTL and testbench

LED_DIMMER -- requirements
Module: led_dimmer

---
 rtl/led_dimmer.sv | 136 +++++++++++++
 tb/tb_led_dimmer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_dimmer.sv
// PWM LED dimmer with bus-written target level and stepped fade.
// Define LED_DIMMER_BLINK_EN to add the per-LED blink mask at address 29.
module led_dimmer #(
  parameter int PRESCALE = 1000,
  parameter int RAMP_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D,
  input  logic [4:0] dir,
  input  logic       MemWrite,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic [3:0] level,
  output logic       busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_cnt_q, presc_cnt_d;
  logic [3:0]      pwm_cnt_q, pwm_cnt_d;
  logic [RW-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [3:0]      tgt_q, tgt_d;
  logic [3:0]      level_q, level_d;
  logic [3:0]      led_out_q, led_out_d;
  logic            busy_q, busy_d;

  logic tick;
  logic pend;
  logic up;
  logic dn;
  logic on;
  logic [3:0] blank;

`ifdef LED_DIMMER_BLINK_EN
  logic [3:0] mask_q, mask_d;
  logic [5:0] per_cnt_q, per_cnt_d;
  logic       phase_q, phase_d;
`endif

  always_comb begin
    tick = (presc_cnt_q == PW'(PRESCALE - 1));
    pend = tick && (pwm_cnt_q == 4'hf);
    up   = (tgt_q > level_q);
    dn   = (tgt_q < level_q);
    on   = (pwm_cnt_q < level_q) || (level_q == 4'hf);

    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q + {3'b000, tick};
    tgt_d       = (MemWrite && dir == 5'd30) ? D : tgt_q;
    state_d     = state_q;
    level_d     = level_q;
    ramp_cnt_d  = ramp_cnt_q;
    blank       = 4'h0;

`ifdef LED_DIMMER_BLINK_EN
    mask_d    = (MemWrite && dir == 5'd29) ? D : mask_q;
    per_cnt_d = per_cnt_q + {5'b0, pend};
    phase_d   = (pend && per_cnt_q == 6'd63) ? ~phase_q : phase_q;
    blank     = phase_q ? 4'h0 : mask_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (up)      state_d = RAMP_UP;
        else if (dn) state_d = RAMP_DOWN;
      end
      RAMP_UP, RAMP_DOWN: begin
        if (!up && !dn) begin
          state_d    = IDLE;
          ramp_cnt_d = '0;
        end else begin
          // direction follows tgt so a mid-ramp rewrite never overshoots
          state_d = up ? RAMP_UP : RAMP_DOWN;
          if (pend) begin
            if (ramp_cnt_q == RW'(RAMP_DIV - 1)) begin
              ramp_cnt_d = '0;
              level_d    = up ? level_q + 4'd1 : level_q - 4'd1;
            end else begin
              ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    led_out_d = led_in & {4{on}} & ~blank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      ramp_cnt_q  <= '0;
      tgt_q       <= 4'hf;
      level_q     <= 4'hf;
      led_out_q   <= 4'h0;
      busy_q      <= 1'b0;
`ifdef LED_DIMMER_BLINK_EN
      mask_q      <= 4'h0;
      per_cnt_q   <= '0;
      phase_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      ramp_cnt_q  <= ramp_cnt_d;
      tgt_q       <= tgt_d;
      level_q     <= level_d;
      led_out_q   <= led_out_d;
      busy_q      <= busy_d;
`ifdef LED_DIMMER_BLINK_EN
      mask_q      <= mask_d;
      per_cnt_q   <= per_cnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign led_out = led_out_q;
  assign level   = level_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_dimmer.sv
// Bench for led_dimmer: time-based reference model plus directed
// fade scenarios and randomized bus/reset traffic.
module tb_led_dimmer;
  localparam int P  = 2;
  localparam int RD = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] D = 4'h0;
  logic [4:0] dir = 5'd0;
  logic       MemWrite = 1'b0;
  logic [3:0] led_in = 4'hf;
  logic [3:0] led_out;
  logic [3:0] level;
  logic       busy;

  led_dimmer #(.PRESCALE(P), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .D(D), .dir(dir),
    .MemWrite(MemWrite), .led_in(led_in),
    .led_out(led_out), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;
  bit model_ok = 1'b0;

  int n;
  int m_tgt, m_level, m_rc;
  bit m_busy;
  logic [3:0] m_led;
`ifdef LED_DIMMER_BLINK_EN
  logic [3:0] m_mask;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // Model: counters are pure functions of edges since reset release;
  // busy next = (tgt != level); level moves one step toward tgt
  // every RD period ends while busy.
  always @(posedge clk) begin : model
    int pwm, nl, nrc;
    bit pend;
    logic [3:0] gate, boff;
    if (!rst_n) begin
      n = 0; m_tgt = 15; m_level = 15; m_rc = 0;
      m_busy = 0; m_led = 4'h0; model_ok = 1'b1;
`ifdef LED_DIMMER_BLINK_EN
      m_mask = 4'h0;
`endif
    end else begin
      pwm  = (n / P) % 16;
      pend = (n % (16 * P)) == (16 * P - 1);
      gate = (pwm < m_level || m_level == 15) ? 4'hf : 4'h0;
      boff = 4'h0;
`ifdef LED_DIMMER_BLINK_EN
      if (((n / (1024 * P)) % 2) == 1) boff = m_mask;
      if (MemWrite && dir == 5'd29) m_mask = D;
`endif
      nl = m_level;
      nrc = m_rc;
      if (m_busy && m_tgt != m_level) begin
        if (pend) begin
          if (m_rc == RD - 1) begin
            nrc = 0;
            nl = (m_tgt > m_level) ? m_level + 1 : m_level - 1;
          end else nrc = m_rc + 1;
        end
      end else if (m_busy) nrc = 0;
      m_busy = (m_tgt != m_level);
      m_led = led_in & gate & ~boff;
      m_level = nl;
      m_rc = nrc;
      if (MemWrite && dir == 5'd30) m_tgt = int'(D);
      n++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("level", int'(level), m_level);
      chk("busy", int'(busy), int'(m_busy));
      chk("led_out", int'(led_out), int'(m_led));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input int d, input bit we);
    MemWrite = we;
    dir = 5'(a);
    D = 4'(d);
    cyc(1);
    MemWrite = 1'b0;
    dir = 5'd0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      cyc(1);
      if (!busy) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_level(input string name, input int v, input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      cyc(1);
      if (int'(level) == v) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    int cnt, mn;
    rst_n = 1'b0;
    led_in = 4'hf;
    cyc(1);
    chk("rst_led_out", int'(led_out), 0);
    chk("rst_level", int'(level), 15);
    chk("rst_busy", int'(busy), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("full_on", int'(led_out), 15);

    wr(30, 8, 1);
    cyc(1);
    chk("busy_after_wr", int'(busy), 1);
    wait_idle("wait_fade8", 400);
    chk("level8", int'(level), 8);
    cnt = 0;
    repeat (32) begin
      cyc(1);
      if (led_out == 4'hf) cnt++;
    end
    chk("duty8_on_cycles", cnt, 16);

    wr(30, 0, 1);
    cyc(1);
    wait_idle("wait_fade0", 1000);
    chk("level0", int'(level), 0);
    cnt = 0;
    repeat (200) begin
      cyc(1);
      if (led_out != 4'h0) cnt++;
    end
    chk("dark_cycles", cnt, 0);

    wr(30, 15, 1);
    cyc(1);
    wait_idle("wait_fade15", 1000);
    wr(30, 4, 1);
    wait_level("wait_lvl12", 12, 1000);
    wr(30, 14, 1);
    mn = int'(level);
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (int'(level) < mn) mn = int'(level);
      if (!busy) break;
    end
    chk("no_dip_below12", mn, 12);
    chk("level14", int'(level), 14);
    chk("idle14", int'(busy), 0);

    wr(31, 0, 1);
    wr(30, 0, 0);
    cyc(2);
    chk("ign_level", int'(level), 14);
    chk("ign_busy", int'(busy), 0);

    wr(30, 0, 1);
    wait_level("wait_lvl10", 10, 1000);
    rst_n = 1'b0;
    MemWrite = 1'b1;
    dir = 5'd30;
    D = 4'd3;
    cyc(1);
    rst_n = 1'b1;
    MemWrite = 1'b0;
    chk("rst_mid_level", int'(level), 15);
    chk("rst_mid_busy", int'(busy), 0);
    cyc(3);
    chk("rst_drop_wr", int'(busy), 0);

    for (int i = 0; i < 4000; i++) begin
      led_in = 4'($urandom);
      MemWrite = ($urandom % 40) == 0;
      case ($urandom % 4)
        0: dir = 5'd29;
        1: dir = 5'd30;
        2: dir = 5'd31;
        default: dir = 5'($urandom);
      endcase
      D = 4'($urandom);
      rst_n = ($urandom % 1500) != 0;
      cyc(1);
    end
    MemWrite = 1'b0;
    rst_n = 1'b1;
    cyc(2);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
